// File: rtl/bubble_sort_pkg.sv
// Purpose: shared state encoding for the bubble-sort control FSM.
// Contents: STATE_W and one localparam per FSM state (IDLE..DONE).
package bubble_sort_pkg;

    localparam int unsigned STATE_W = 4;

    localparam logic [STATE_W-1:0] S_IDLE   = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_INIT   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_CHK_I  = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_INC_J  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_RD_I   = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_RD_J   = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_CMP    = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_WR_I   = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_WR_J   = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_NEXT_J = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_NEXT_I = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_DONE   = STATE_W'(11);

endpackage

// File: rtl/bubble_sort_controller.sv
// Purpose: Moore control FSM for the in-place ascending bubble-sort datapath.
//   Outer index i lives in C1, inner index j in C2; mem[i]/mem[j] swap when mem[j] < mem[i].
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 begin a sort (sampled only in IDLE)
//   CO1, CO2              C1 / C2 hold the last index
//   lt, gt                Reg2 < Reg1 / Reg2 > Reg1 (gt not used for control)
//   S0, S1                address select (0=C1,1=C2) / write-data select (0=Reg1,1=Reg2)
//   Reg1_ld, Reg2_ld      load data registers from memory read data
//   C1_clr/inc/ld         C1 controls (C1_ld tied low)
//   C2_clr/inc/ld         C2 controls (C2_ld copies C1, C2_clr tied low)
//   rd, wr                memory read / write strobes
//   busy, done            busy outside IDLE, one-cycle completion pulse
module bubble_sort_controller
    import bubble_sort_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic CO1,
    input  logic CO2,
    input  logic lt,
    input  logic gt,
    output logic S0,
    output logic S1,
    output logic Reg1_ld,
    output logic Reg2_ld,
    output logic C1_clr,
    output logic C1_inc,
    output logic C1_ld,
    output logic C2_clr,
    output logic C2_inc,
    output logic C2_ld,
    output logic rd,
    output logic wr,
    output logic busy,
    output logic done
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic               w_unused_gt;

    // gt is part of the datapath status bundle but the ordering only needs lt
    assign w_unused_gt = gt;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flags are consumed only in the state that tests them
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = start ? S_INIT : S_IDLE;
            S_INIT:   w_next = S_CHK_I;
            S_CHK_I:  w_next = CO1 ? S_DONE : S_INC_J;
            S_INC_J:  w_next = S_RD_I;
            S_RD_I:   w_next = S_RD_J;
            S_RD_J:   w_next = S_CMP;
            S_CMP:    w_next = lt ? S_WR_I : S_NEXT_J;
            S_WR_I:   w_next = S_WR_J;
            S_WR_J:   w_next = S_NEXT_J;
            // CO2 reflects j before this state's increment lands
            S_NEXT_J: w_next = CO2 ? S_NEXT_I : S_RD_I;
            S_NEXT_I: w_next = S_CHK_I;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Output decode: pure function of state
    always_comb begin
        S0      = 1'b0;
        S1      = 1'b0;
        Reg1_ld = 1'b0;
        Reg2_ld = 1'b0;
        C1_clr  = 1'b0;
        C1_inc  = 1'b0;
        C1_ld   = 1'b0;
        C2_clr  = 1'b0;
        C2_inc  = 1'b0;
        C2_ld   = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        busy    = (r_state != S_IDLE);
        done    = 1'b0;
        case (r_state)
            S_INIT:   C1_clr = 1'b1;
            S_CHK_I:  C2_ld  = 1'b1;
            S_INC_J:  C2_inc = 1'b1;
            S_RD_I: begin
                rd      = 1'b1;
                Reg1_ld = 1'b1;
            end
            S_RD_J: begin
                S0      = 1'b1;
                rd      = 1'b1;
                Reg2_ld = 1'b1;
            end
            // mem[i] <= Reg2
            S_WR_I: begin
                S1 = 1'b1;
                wr = 1'b1;
            end
            // mem[j] <= Reg1
            S_WR_J: begin
                S0 = 1'b1;
                wr = 1'b1;
            end
            S_NEXT_J: C2_inc = 1'b1;
            S_NEXT_I: C1_inc = 1'b1;
            S_DONE:   done   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bubble_sort_controller.sv
// Bench for bubble_sort_controller: behavioural datapath plus table of sort jobs,
// expected results queued at start and checked when done arrives.
module tb_bubble_sort_controller;
    import bubble_sort_pkg::*;

    typedef logic [3:0][7:0] arr_t;
    typedef struct {
        int   n;
        arr_t din;
        arr_t dexp;
        int   swaps;
        int   lat;
        bit   pulse_mid;
    } vec_t;
    typedef struct {
        arr_t dexp;
        int   swaps;
        int   lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic CO1, CO2, lt, gt;
    logic S0, S1, Reg1_ld, Reg2_ld, C1_clr, C1_inc, C1_ld, C2_clr, C2_inc, C2_ld;
    logic rd, wr, busy, done;

    int checks = 0;
    int errors = 0;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    bubble_sort_controller dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .CO1(CO1), .CO2(CO2), .lt(lt), .gt(gt),
        .S0(S0), .S1(S1), .Reg1_ld(Reg1_ld), .Reg2_ld(Reg2_ld),
        .C1_clr(C1_clr), .C1_inc(C1_inc), .C1_ld(C1_ld),
        .C2_clr(C2_clr), .C2_inc(C2_inc), .C2_ld(C2_ld),
        .rd(rd), .wr(wr), .busy(busy), .done(done)
    );

    // Behavioural datapath: memory, counters, data registers
    logic [7:0] mem [8];
    logic [3:0] c1 = '0;
    logic [3:0] c2 = '0;
    logic [7:0] reg1 = '0;
    logic [7:0] reg2 = '0;
    logic [3:0] addr;
    logic [7:0] rdata;
    int         n_cur = 4;
    logic       ld_en = 1'b0;
    arr_t       ld_data = '0;

    assign addr  = S0 ? c2 : c1;
    assign rdata = mem[addr[2:0]];
    assign CO1   = (c1 == 4'(n_cur - 1));
    assign CO2   = (c2 == 4'(n_cur - 1));
    assign lt    = (reg2 < reg1);
    assign gt    = (reg2 > reg1);

    always @(posedge clk) begin
        if (ld_en) begin
            for (int i = 0; i < 4; i++) mem[i] <= ld_data[i];
        end else if (wr) begin
            mem[addr[2:0]] <= S1 ? reg2 : reg1;
        end
        if (C1_clr)      c1 <= '0;
        else if (C1_inc) c1 <= c1 + 4'd1;
        else if (C1_ld)  c1 <= c2;
        if (C2_ld)       c2 <= c1;
        else if (C2_inc) c2 <= c2 + 4'd1;
        else if (C2_clr) c2 <= '0;
        if (Reg1_ld) reg1 <= rdata;
        if (Reg2_ld) reg2 <= rdata;
    end

    // Event counters and protocol monitor
    int done_cnt = 0;
    int swap_cnt = 0;
    int proto_err = 0;
    bit prev_wr_i = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt <= done_cnt + 1;
            if (wr && !S0) swap_cnt <= swap_cnt + 1;
            if (wr && rd) proto_err <= proto_err + 1;
            if (wr && !S0 && !S1) proto_err <= proto_err + 1;
            if (prev_wr_i && !(wr && S0 && !S1)) proto_err <= proto_err + 1;
            prev_wr_i <= wr && !S0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_mem(input string name, input arr_t exp);
        arr_t act;
        for (int i = 0; i < 4; i++) act[i] = mem[i];
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic arr_t mk(input logic [7:0] a0, input logic [7:0] a1,
                                input logic [7:0] a2, input logic [7:0] a3);
        arr_t r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
        return r;
    endfunction

    // Called at the negedge one cycle after start was sampled (cycle 1)
    task automatic wait_done(output int lat, input bit pulse_mid);
        lat = -1;
        for (int k = 1; k <= 500; k++) begin
            if (pulse_mid && k == 5) start = 1'b1;
            if (pulse_mid && k == 6) start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 500 cycles");
        end
    endtask

    task automatic load_mem(input int n, input arr_t d);
        @(negedge clk);
        n_cur = n;
        ld_data = d;
        ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   sw0, d0, lat;
        exp_t e;
        load_mem(v.n, v.din);
        #1;
        sw0 = swap_cnt;
        d0  = done_cnt;
        @(negedge clk);
        start = 1'b1;
        sb_q.push_back('{v.dexp, v.swaps, v.lat});
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, v.pulse_mid);
        e = sb_q.pop_front();
        chk($sformatf("v%0d_latency", idx), lat, e.lat);
        repeat (3) @(negedge clk);
        #1;
        chk($sformatf("v%0d_swaps", idx), swap_cnt - sw0, e.swaps);
        chk($sformatf("v%0d_done_pulses", idx), done_cnt - d0, 1);
        chk($sformatf("v%0d_busy_after", idx), int'(busy), 0);
        chk_mem($sformatf("v%0d_mem", idx), e.dexp);
    endtask

    function automatic int outs();
        return int'({S0, S1, Reg1_ld, Reg2_ld, C1_clr, C1_inc, C1_ld,
                     C2_clr, C2_inc, C2_ld, rd, wr, busy, done});
    endfunction

    vec_t vecs[7];

    initial begin
        int   lat, d0, seen;
        exp_t e;

        vecs[0] = '{2, mk(5, 3, 0, 0), mk(3, 5, 0, 0), 1, 12, 1'b0};
        vecs[1] = '{2, mk(3, 5, 0, 0), mk(3, 5, 0, 0), 0, 10, 1'b0};
        vecs[2] = '{4, mk(4, 3, 2, 1), mk(1, 2, 3, 4), 6, 48, 1'b0};
        vecs[3] = '{4, mk(7, 7, 7, 7), mk(7, 7, 7, 7), 0, 36, 1'b0};
        vecs[4] = '{4, mk(2, 1, 4, 3), mk(1, 2, 3, 4), 2, 40, 1'b1};
        vecs[5] = '{3, mk(9, 0, 5, 8'hAA), mk(0, 5, 9, 8'hAA), 2, 25, 1'b0};
        vecs[6] = '{1, mk(6, 1, 2, 3), mk(6, 1, 2, 3), 0, 3, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", outs(), 0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Asynchronous reset in the middle of RD_J
        load_mem(2, mk(5, 3, 0, 0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int k = 0; k < 50; k++) begin
            if (rd && S0) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("reached_rd_j", seen, 1);
        rst_n = 1'b0;
        #1;
        chk("midsort_reset_outputs", outs(), 0);
        chk("midsort_reset_busy", int'(busy), 0);
        chk("midsort_reset_state", int'(dut.r_state), int'(S_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        // start held high through DONE relaunches the sort
        load_mem(2, mk(5, 3, 0, 0));
        #1;
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        sb_q.push_back('{mk(3, 5, 0, 0), 1, 12});
        @(negedge clk);
        wait_done(lat, 1'b0);
        e = sb_q.pop_front();
        chk("held_first_latency", lat, e.lat);
        @(negedge clk);
        chk("held_idle_gap_busy", int'(busy), 0);
        sb_q.push_back('{mk(3, 5, 0, 0), 0, 10});
        @(negedge clk);
        chk("held_restart_init", int'(C1_clr && busy), 1);
        start = 1'b0;
        wait_done(lat, 1'b0);
        e = sb_q.pop_front();
        chk("held_second_latency", lat, e.lat);
        repeat (3) @(negedge clk);
        #1;
        chk("held_done_pulses", done_cnt - d0, 2);
        chk_mem("held_mem", e.dexp);
        chk("held_busy_after", int'(busy), 0);

        chk("protocol_errors", proto_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
